// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: single-outstanding req/ack bus, big-endian lanes,
// load extension, LL/SC link (MEM_LLSC_EN), address-error and bus-timeout exceptions.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  input  logic        Flush,
  input  logic        LinkClear,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [4:0]  RegDstOut,
  output logic        MemStall,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWdata,
  input  logic        BusAck,
  input  logic [31:0] BusRdata,
  output logic        WbValid,
  output logic        WbRegWrite,
  output logic [4:0]  WbRd,
  output logic [31:0] WbData,
  output logic        ExcAdEL,
  output logic        ExcAdES,
  output logic        ExcBusErr,
  output logic [31:0] BadVAddr
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t            state_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        be_q;
  logic              we_q, byte_q, half_q, sext_q, llsc_q, m2r_q, regwr_q, flush_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              wb_valid_q, wb_regwr_q, adel_q, ades_q, buserr_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q, bad_q;

  logic [1:0]        off;
  logic              mem_op, misal, sc_fail, start, to_last, bus_kill;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d, load_d, ack_data_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign off    = ALUResult[1:0];
  assign mem_op = InValid & (MemRead | MemWrite);
  assign misal  = MemByte ? 1'b0 : (MemHalf ? off[0] : (off != 2'b00));

`ifdef MEM_LLSC_EN
  logic        link_valid_q;
  logic [29:0] link_addr_q;
  assign sc_fail = LLSC & MemWrite & !(link_valid_q & (link_addr_q == ALUResult[31:2]));
`else
  logic unused_linkclear;
  assign unused_linkclear = LinkClear;
  assign sc_fail = 1'b0;
`endif

  assign start    = mem_op & !Flush & !misal & !sc_fail;
  assign to_last  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_M1));
  assign bus_kill = flush_q | Flush;

  // Stall is combinational so EX/MEM freezes the same cycle the op is seen.
  assign MemStall = (state_q == IDLE) ? start : (!BusAck & !to_last);

  assign BusReq   = (state_q == BUS);
  assign BusWe    = BusReq & we_q;
  assign BusAddr  = BusReq ? {addr_q[31:2], 2'b00} : 32'h0;
  assign BusBe    = BusReq ? be_q : 4'h0;
  assign BusWdata = BusReq ? wdata_q : 32'h0;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ReadData2;
    if (MemByte) begin
      be_d    = 4'b1000 >> off;
      wdata_d = {4{ReadData2[7:0]}};
    end else if (MemHalf) begin
      be_d    = off[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{ReadData2[15:0]}};
    end
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    ld_byte = BusRdata[31:24];
    case (addr_q[1:0])
      2'd0: ld_byte = BusRdata[31:24];
      2'd1: ld_byte = BusRdata[23:16];
      2'd2: ld_byte = BusRdata[15:8];
      default: ld_byte = BusRdata[7:0];
    endcase
    ld_half = addr_q[1] ? BusRdata[15:0] : BusRdata[31:16];
    if (byte_q)
      load_d = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
    else if (half_q)
      load_d = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
    else
      load_d = BusRdata;
    if (llsc_q & we_q)
      ack_data_d = 32'd1;
    else if (!we_q & m2r_q)
      ack_data_d = load_d;
    else
      ack_data_d = addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      sext_q     <= 1'b0;
      llsc_q     <= 1'b0;
      m2r_q      <= 1'b0;
      regwr_q    <= 1'b0;
      flush_q    <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      buserr_q   <= 1'b0;
      bad_q      <= '0;
`ifdef MEM_LLSC_EN
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (InValid & !Flush) begin
            if (!mem_op) begin
              wb_valid_q <= 1'b1;
              wb_regwr_q <= RegWrite;
              wb_rd_q    <= RegDstOut;
              wb_data_q  <= ALUResult;
            end else if (misal) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= RegDstOut;
              wb_data_q  <= ALUResult;
              adel_q     <= !MemWrite;
              ades_q     <= MemWrite;
              bad_q      <= ALUResult;
            end else if (sc_fail) begin
              wb_valid_q <= 1'b1;
              wb_regwr_q <= RegWrite;
              wb_rd_q    <= RegDstOut;
              wb_data_q  <= 32'h0;
            end else begin
              state_q <= BUS;
              addr_q  <= ALUResult;
              wdata_q <= wdata_d;
              be_q    <= be_d;
              we_q    <= MemWrite;
              byte_q  <= MemByte;
              half_q  <= MemHalf;
              sext_q  <= MemSignExtend;
              llsc_q  <= LLSC;
              m2r_q   <= MemtoReg;
              regwr_q <= RegWrite;
              rd_q    <= RegDstOut;
              flush_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        BUS: begin
          if (Flush) flush_q <= 1'b1;
          if (BusAck) begin
            state_q    <= IDLE;
            wb_valid_q <= !bus_kill;
            wb_regwr_q <= regwr_q & !bus_kill;
            wb_rd_q    <= rd_q;
            wb_data_q  <= ack_data_d;
`ifdef MEM_LLSC_EN
            if (!bus_kill & llsc_q) begin
              link_valid_q <= !we_q;
              if (!we_q) link_addr_q <= addr_q[31:2];
            end
`endif
          end else if (to_last) begin
            state_q    <= IDLE;
            wb_valid_q <= !bus_kill;
            buserr_q   <= !bus_kill;
            if (!bus_kill) bad_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef MEM_LLSC_EN
      // Clear wins over a same-cycle LL ack set.
      if (LinkClear) link_valid_q <= 1'b0;
`endif
    end
  end

  assign WbValid    = wb_valid_q;
  assign WbRegWrite = wb_regwr_q;
  assign WbRd       = wb_rd_q;
  assign WbData     = wb_data_q;
  assign ExcAdEL    = adel_q;
  assign ExcAdES    = ades_q;
  assign ExcBusErr  = buserr_q;
  assign BadVAddr   = bad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a retire scoreboard (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        InValid, Flush, LinkClear;
  logic        MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, RegWrite, MemtoReg;
  logic [31:0] ALUResult, ReadData2;
  logic [4:0]  RegDstOut;
  logic        MemStall, BusReq, BusWe, BusAck;
  logic [31:0] BusAddr, BusWdata, BusRdata;
  logic [3:0]  BusBe;
  logic        WbValid, WbRegWrite, ExcAdEL, ExcAdES, ExcBusErr;
  logic [4:0]  WbRd;
  logic [31:0] WbData, BadVAddr;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Flush(Flush), .LinkClear(LinkClear),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemHalf(MemHalf), .MemByte(MemByte),
    .MemSignExtend(MemSignExtend), .LLSC(LLSC), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .RegDstOut(RegDstOut),
    .MemStall(MemStall), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
    .BusWdata(BusWdata), .BusAck(BusAck), .BusRdata(BusRdata),
    .WbValid(WbValid), .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
    .ExcAdEL(ExcAdEL), .ExcAdES(ExcAdES), .ExcBusErr(ExcBusErr), .BadVAddr(BadVAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, hf, by, sx, ll, rw, m2r;
    logic [31:0] alu, rd2;
    logic [4:0]  rdst;
    logic        lclr, fl_idle;
    int          flush_cyc;
    logic        bus;
    int          ack_cyc;
    logic [31:0] rdata, e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_valid, e_rw, e_adel, e_ades, e_berr;
    logic [31:0] e_data, e_bad;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nchecks = 0;
  int   nerr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // c = {rd, wr, half, byte, sext, llsc, regwrite, memtoreg}
  function automatic vec_t mk(input logic [7:0] c, input logic [31:0] alu, input logic [31:0] rd2,
                              input logic [4:0] rdst);
    vec_t v;
    {v.rd, v.wr, v.hf, v.by, v.sx, v.ll, v.rw, v.m2r} = c;
    v.alu = alu; v.rd2 = rd2; v.rdst = rdst;
    v.lclr = 1'b0; v.fl_idle = 1'b0; v.flush_cyc = 0;
    v.bus = 1'b0; v.ack_cyc = 0; v.rdata = '0; v.e_addr = '0; v.e_wdata = '0; v.e_be = '0;
    v.e_valid = 1'b1; v.e_rw = 1'b0; v.e_adel = 1'b0; v.e_ades = 1'b0; v.e_berr = 1'b0;
    v.e_data = '0; v.e_bad = '0;
    return v;
  endfunction

  function automatic vec_t bx(input vec_t vi, input int ack, input logic [31:0] rdata,
                              input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    vec_t v = vi;
    v.bus = 1'b1; v.ack_cyc = ack; v.rdata = rdata; v.e_addr = addr; v.e_be = be; v.e_wdata = wd;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic [31:0] data, input logic rw);
    vec_t v = vi;
    v.e_data = data; v.e_rw = rw;
    return v;
  endfunction

  function automatic vec_t xc(input vec_t vi, input logic adel, input logic ades, input logic berr,
                              input logic [31:0] bad);
    vec_t v = vi;
    v.e_adel = adel; v.e_ades = ades; v.e_berr = berr; v.e_bad = bad; v.e_rw = 1'b0;
    return v;
  endfunction

  // Scoreboard: every visible retire must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && WbValid) begin
      if (sb.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL unexpected_retire: WbValid=1 with empty scoreboard at %0t", $time);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("wb_regwrite", {31'h0, WbRegWrite}, {31'h0, e.e_rw});
        chk("exc_adel", {31'h0, ExcAdEL}, {31'h0, e.e_adel});
        chk("exc_ades", {31'h0, ExcAdES}, {31'h0, e.e_ades});
        chk("exc_buserr", {31'h0, ExcBusErr}, {31'h0, e.e_berr});
        if (e.e_adel | e.e_ades | e.e_berr)
          chk("badvaddr", BadVAddr, e.e_bad);
        else begin
          chk("wb_data", WbData, e.e_data);
          chk("wb_rd", {27'h0, WbRd}, {27'h0, e.rdst});
        end
      end
    end
  end

  task automatic run(input vec_t v);
    logic done, last;
    {MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, RegWrite, MemtoReg} =
      {v.rd, v.wr, v.hf, v.by, v.sx, v.ll, v.rw, v.m2r};
    ALUResult = v.alu; ReadData2 = v.rd2; RegDstOut = v.rdst;
    InValid = 1'b1; Flush = v.fl_idle; LinkClear = v.lclr;
    if (v.e_valid) sb.push_back(v);
    @(negedge clk);
    chk("stall_idle", {31'h0, MemStall}, {31'h0, v.bus});
    chk("busreq_idle", {31'h0, BusReq}, 32'h0);
    if (v.bus) begin
      @(posedge clk); #1;
      Flush = 1'b0; LinkClear = 1'b0;
      done = 1'b0;
      for (int c = 1; c <= 20 && !done; c++) begin
        BusAck = (c == v.ack_cyc); BusRdata = v.rdata; Flush = (c == v.flush_cyc);
        last = (c == v.ack_cyc) || (c == TO);
        @(negedge clk);
        chk("busreq_bus", {31'h0, BusReq}, 32'h1);
        if (c == 1) begin
          chk("bus_addr", BusAddr, v.e_addr);
          chk("bus_be", {28'h0, BusBe}, {28'h0, v.e_be});
          chk("bus_wdata", BusWdata, v.e_wdata);
          chk("bus_we", {31'h0, BusWe}, {31'h0, v.wr});
        end
        chk("stall_bus", {31'h0, MemStall}, {31'h0, !last});
        @(posedge clk); #1;
        if (last) done = 1'b1;
      end
      if (!done) begin
        nchecks++; nerr++;
        $display("FAIL bus_bound: transaction did not finish in 20 cycles");
      end
    end else begin
      @(posedge clk); #1;
    end
    InValid = 1'b0; Flush = 1'b0; LinkClear = 1'b0; BusAck = 1'b0;
    @(negedge clk);
    chk("busreq_after", {31'h0, BusReq}, 32'h0);
    if (!v.e_valid) chk("no_retire", {31'h0, WbValid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pulse", {28'h0, WbValid, ExcAdEL, ExcAdES, ExcBusErr}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; InValid = 1'b0; Flush = 1'b0; LinkClear = 1'b0;
    {MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, RegWrite, MemtoReg} = '0;
    ALUResult = '0; ReadData2 = '0; RegDstOut = '0; BusAck = 1'b0; BusRdata = '0;

    tbl.push_back(ex(bx(mk(8'b1001_1011, 32'h1003, 0, 5'd3), 1, 32'h112233F0, 32'h1000, 4'b0001, 0), 32'hFFFFFFF0, 1));
    tbl.push_back(ex(bx(mk(8'b1001_0011, 32'h1003, 0, 5'd4), 1, 32'h112233F0, 32'h1000, 4'b0001, 0), 32'h000000F0, 1));
    tbl.push_back(ex(bx(mk(8'b0110_0000, 32'h2002, 32'h0000BEEF, 5'd0), 2, 0, 32'h2000, 4'b0011, 32'hBEEFBEEF), 32'h2002, 0));
    tbl.push_back(xc(mk(8'b1000_0011, 32'h1002, 0, 5'd5), 1, 0, 0, 32'h1002));
    tbl.push_back(xc(mk(8'b0100_0000, 32'h1001, 0, 5'd0), 0, 1, 0, 32'h1001));
    tbl.push_back(ex(bx(mk(8'b1010_1011, 32'h4002, 0, 5'd6), 3, 32'h12348001, 32'h4000, 4'b0011, 0), 32'hFFFF8001, 1));
    tbl.push_back(ex(bx(mk(8'b1000_0010, 32'h5000, 0, 5'd7), 1, 32'hDEADBEEF, 32'h5000, 4'b1111, 0), 32'h5000, 1));
    tbl.push_back(ex(bx(mk(8'b0101_0000, 32'h6001, 32'h000000A5, 5'd0), 1, 0, 32'h6000, 4'b0100, 32'hA5A5A5A5), 32'h6001, 0));
    tbl.push_back(ex(mk(8'b0000_0010, 32'h12345678, 0, 5'd7), 32'h12345678, 1));
    // LL/SC: link hit, link miss, LinkClear
    tbl.push_back(ex(bx(mk(8'b1000_0111, 32'h3000, 0, 5'd8), 1, 32'h0BADF00D, 32'h3000, 4'b1111, 0), 32'h0BADF00D, 1));
`ifdef MEM_LLSC_EN
    tbl.push_back(ex(mk(8'b0100_0110, 32'h3004, 32'h55, 5'd9), 32'h0, 1));
`else
    tbl.push_back(ex(bx(mk(8'b0100_0110, 32'h3004, 32'h55, 5'd9), 1, 0, 32'h3004, 4'b1111, 32'h55), 32'h1, 1));
`endif
    tbl.push_back(ex(bx(mk(8'b0100_0110, 32'h3000, 32'h66, 5'd10), 2, 0, 32'h3000, 4'b1111, 32'h66), 32'h1, 1));
    tbl.push_back(ex(bx(mk(8'b1000_0111, 32'h3000, 0, 5'd8), 1, 32'h0BADF00D, 32'h3000, 4'b1111, 0), 32'h0BADF00D, 1));
    v = ex(mk(8'b0000_0000, 32'h0, 0, 5'd0), 32'h0, 0); v.lclr = 1'b1; tbl.push_back(v);
`ifdef MEM_LLSC_EN
    tbl.push_back(ex(mk(8'b0100_0110, 32'h3000, 32'h77, 5'd11), 32'h0, 1));
`else
    tbl.push_back(ex(bx(mk(8'b0100_0110, 32'h3000, 32'h77, 5'd11), 1, 0, 32'h3000, 4'b1111, 32'h77), 32'h1, 1));
`endif
    // Timeout, flush mid-bus, flush in idle
    tbl.push_back(xc(bx(mk(8'b1000_0011, 32'h7000, 0, 5'd12), 0, 0, 32'h7000, 4'b1111, 0), 0, 0, 1, 32'h7000));
    v = bx(mk(8'b1000_0011, 32'h8000, 0, 5'd13), 4, 32'h11111111, 32'h8000, 4'b1111, 0);
    v.flush_cyc = 2; v.e_valid = 1'b0; tbl.push_back(v);
    v = mk(8'b0100_0000, 32'h9000, 32'h1, 5'd0); v.fl_idle = 1'b1; v.e_valid = 1'b0; tbl.push_back(v);

    #3;
    chk("rst_busreq", {31'h0, BusReq}, 32'h0);
    chk("rst_stall", {31'h0, MemStall}, 32'h0);
    chk("rst_wb", {28'h0, WbValid, WbRegWrite, ExcAdEL, ExcAdES}, 32'h0);
    chk("rst_wbdata", WbData, 32'h0);
    chk("rst_busaddr", BusAddr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset asserted mid-transfer must drop BusReq without waiting for a clock.
    {MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, RegWrite, MemtoReg} = 8'b1000_0011;
    ALUResult = 32'h9000; RegDstOut = 5'd14; InValid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busreq_pre", {31'h0, BusReq}, 32'h1);
    #1 InValid = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_busreq", {31'h0, BusReq}, 32'h0);
    chk("midrst_busaddr", BusAddr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {31'h0, BusReq}, 32'h0);
    @(posedge clk); #1;
    run(ex(mk(8'b0000_0010, 32'hCAFE0000, 0, 5'd15), 32'hCAFE0000, 1));

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM bundle: memory control bits, ALUResult, ReadData2, RegDstOut, RegWrite, MemtoReg.
- Drives a single-outstanding req/ack data bus and produces registered MEM/WB results.
- Handles byte-lane alignment (big-endian), load extension, LL/SC link state, address-error and bus-timeout exceptions, and pipeline stall.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles BusReq is held without BusAck before a bus error; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- InValid  in  1  EX/MEM holds a valid instruction.
- Flush  in  1  kill the current instruction (exception/redirect).
- LinkClear  in  1  clear the LL link (ERET/exception entry).
- MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC  in  1 each  EX/MEM control bits.
- RegWrite, MemtoReg  in  1 each  writeback control bits.
- ALUResult  in  32  effective address, or the result for non-memory ops.
- ReadData2  in  32  store data.
- RegDstOut  in  5  destination register.
- MemStall  out  1  hold EX/MEM and all upstream stages.
- BusReq, BusWe  out  1 each  bus request; write enable.
- BusAddr  out  32  word-aligned address, bits [1:0] = 0.
- BusBe  out  4  byte enables; bit 3 = byte at address offset 0.
- BusWdata  out  32  lane-replicated store data.
- BusAck  in  1  transfer complete this cycle.
- BusRdata  in  32  read data, valid with BusAck.
- WbValid, WbRegWrite  out  1 each  MEM/WB valid; register write enable.
- WbRd  out  5  MEM/WB destination register.
- WbData  out  32  MEM/WB write data.
- ExcAdEL, ExcAdES, ExcBusErr  out  1 each  exception flags, valid with WbValid.
- BadVAddr  out  32  faulting address.

Behaviour:
- Reset: every output is 0; state = IDLE; LinkValid = 0; LinkAddr = 0. BusReq drops asynchronously when reset is asserted mid-transfer.
- Memory op: InValid & (MemRead | MemWrite).
- Size: MemByte = byte, MemHalf = half, otherwise word.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- States are IDLE and BUS.
- IDLE, non-memory op: MemStall = 0. Next edge: WbValid = 1, WbData = ALUResult, WbRd = RegDstOut, WbRegWrite = RegWrite.
- IDLE, misaligned: no bus access, MemStall = 0. Next edge: WbValid = 1, WbRegWrite = 0, ExcAdEL (load) or ExcAdES (store) = 1, BadVAddr = ALUResult.
- IDLE, failing SC: LLSC & MemWrite with !(LinkValid & LinkAddr == addr[31:2]). No bus access, MemStall = 0. Next edge: WbData = 0, WbRegWrite = RegWrite.
- IDLE, other memory op: MemStall = 1 combinationally. Latch op, address, data, rd and controls. Next state BUS with timeout counter = 0.
- BUS: BusReq = 1, with BusAddr, BusBe, BusWdata and BusWe stable until the ack edge.
- BUS: MemStall = !BusAck, except 0 in the final timeout cycle.
- BUS, on BusAck: next edge returns to IDLE and retires.
  - Load: WbData = extracted data when MemtoReg, else ALUResult.
  - SC: WbData = 1, LinkValid := 0.
  - LL: LinkValid := 1, LinkAddr := addr[31:2].
- BUS, no BusAck for TIMEOUT_CYCLES consecutive cycles: next edge drops BusReq, returns to IDLE, and retires with ExcBusErr = 1, WbRegWrite = 0, BadVAddr = address.
- Byte lanes:
  - Byte at offset k: BusBe = 4'b1000 >> k, BusWdata = {4{ReadData2[7:0]}}.
  - Half at offset 0: BusBe = 1100. Half at offset 2: BusBe = 0011. BusWdata = {2{ReadData2[15:0]}}.
  - Word: BusBe = 1111.
- Load extraction: select the lane by offset (big-endian); sign-extend when MemSignExtend, else zero-extend.
- Flush:
  - In IDLE it kills the instruction; next edge WbValid = 0 and no bus access.
  - In BUS the transaction is never aborted: BusReq holds until ack or timeout, then retires with WbValid = 0, no exception and no link update. MemStall follows the normal rule.
- Flush has priority over all exception flags.
- LinkClear: LinkValid := 0. It takes priority over a simultaneous LL-ack set.
- WbValid and exception flags are single-cycle pulses.

Optional Feature:
- Macro: MEM_LLSC_EN.
- Defined: LL/SC link tracking exactly as above.
- Undefined:
  - No link registers; LinkClear is ignored.
  - LL behaves as LW.
  - SC always performs the store and returns WbData = 1.

Test Plan:
1. Byte loads:
   - LB addr 0x00001003, BusRdata 0x112233F0, ack next cycle: BusAddr 0x00001000, BusBe 0001, WbData 0xFFFFFFF0.
   - Same access as LBU: WbData 0x000000F0.
2. SH addr 0x00002002, ReadData2 0x0000BEEF: BusWe 1, BusBe 0011, BusWdata 0xBEEFBEEF, BusAddr 0x00002000.
3. Address errors:
   - LW addr 0x00001002: BusReq never asserts, MemStall 0; next cycle ExcAdEL 1, BadVAddr 0x00001002, WbRegWrite 0.
   - SW addr 0x00001001: ExcAdES 1.
4. LL/SC:
   - LL 0x3000 then SC 0x3004: no BusReq, WbData 0.
   - LL 0x3000 then SC 0x3000: store issued, WbData 1.
   - LL, LinkClear, SC 0x3000: WbData 0.
5. TIMEOUT_CYCLES = 4 with BusAck held 0: BusReq high exactly 4 cycles, MemStall low in the 4th, then ExcBusErr 1, WbRegWrite 0.
6. Flush plus reset:
   - Flush in the 2nd BUS cycle, ack in the 4th: BusReq held through the ack, then WbValid 0, no exception.
   - Separately, rst_n low mid-BUS: BusReq 0 immediately, state IDLE.
